// File: rtl/pam_modulator.sv
// Pulse-amplitude modulator: gates signed samples with a programmable pulse train,
// in natural (live sample) or flat-top (sample held from period start) mode.
module pam_modulator #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              mode,
    input  logic [CNT_W-1:0]  period_cfg,
    input  logic [CNT_W-1:0]  width_cfg,
    input  logic [DATA_W-1:0] sample_in,
    output logic [DATA_W-1:0] pam_out,
    output logic              pulse_out,
    output logic              frame_start
);

    localparam logic [CNT_W-1:0] PER_MIN = CNT_W'(2);

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  per_sh_q, per_sh_d;
    logic [CNT_W-1:0]  wid_sh_q, wid_sh_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic [DATA_W-1:0] pam_out_q, pam_out_d;
    logic              pulse_q, pulse_d;
    logic              frame_q, frame_d;

    logic              at_zero;
    logic              start;
    logic [CNT_W-1:0]  per_clamp;
    logic [CNT_W-1:0]  wid_clamp;
    logic [CNT_W-1:0]  per_eff;
    logic [CNT_W-1:0]  wid_eff;

    always_comb begin
        at_zero   = (cnt_q == '0);
        start     = en && at_zero;
        per_clamp = (period_cfg < PER_MIN) ? PER_MIN : period_cfg;
        wid_clamp = (width_cfg < per_clamp) ? width_cfg : per_clamp;
        // At cnt==0 the fresh config governs the period that is starting now.
        per_eff   = at_zero ? per_clamp : per_sh_q;
        wid_eff   = at_zero ? wid_clamp : wid_sh_q;

        cnt_d     = cnt_q;
        per_sh_d  = per_sh_q;
        wid_sh_d  = wid_sh_q;
        hold_d    = hold_q;
        pam_out_d = '0;
        pulse_d   = 1'b0;
        frame_d   = 1'b0;

        if (!en) begin
            cnt_d = '0;
        end else begin
            cnt_d   = (cnt_q == per_eff - CNT_W'(1)) ? '0 : cnt_q + CNT_W'(1);
            pulse_d = (cnt_q < wid_eff);
            if (start) begin
                per_sh_d = per_clamp;
                wid_sh_d = wid_clamp;
                hold_d   = sample_in;
                frame_d  = 1'b1;
            end
            if (pulse_d) begin
                if (!mode || at_zero) begin
                    pam_out_d = sample_in;
                end else begin
                    pam_out_d = hold_q;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            per_sh_q  <= PER_MIN;
            wid_sh_q  <= '0;
            hold_q    <= '0;
            pam_out_q <= '0;
            pulse_q   <= 1'b0;
            frame_q   <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            per_sh_q  <= per_sh_d;
            wid_sh_q  <= wid_sh_d;
            hold_q    <= hold_d;
            pam_out_q <= pam_out_d;
            pulse_q   <= pulse_d;
            frame_q   <= frame_d;
        end
    end

    assign pam_out     = pam_out_q;
    assign pulse_out   = pulse_q;
    assign frame_start = frame_q;

endmodule
